// File: rtl/ram_dp_pipe.sv
// rtl/ram_dp_pipe.sv - simple dual-port RAM, byte enables, pipelined reads, optional RAM_PARITY_EN byte parity
module ram_dp_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int DEPTH          = 16,
    parameter int RD_LATENCY     = 1,
    parameter int COLLISION_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_enb,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_enb,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
`ifdef RAM_PARITY_EN
    input  logic                    wr_par_flip,
    output logic                    parity_err,
`endif
    output logic                    addr_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d  [DEPTH];
    logic                  vld_q  [RD_LATENCY];
    logic                  vld_d  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] data_d [RD_LATENCY];
    logic                  addr_err_q, addr_err_d;
    logic                  wr_in_range, rd_in_range, wr_fire;
    logic [DATA_WIDTH-1:0] rd_word;
`ifdef RAM_PARITY_EN
    logic [NB-1:0]         par_q  [DEPTH];
    logic [NB-1:0]         par_d  [DEPTH];
    logic                  perr_q [RD_LATENCY];
    logic                  perr_d [RD_LATENCY];
    logic [NB-1:0]         rd_par;
    logic                  rd_perr;
`endif

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_A);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_A);
    assign wr_fire     = wr_enb & wr_in_range;

    always_comb begin
        mem_d = mem_q;
        if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem_d[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

`ifdef RAM_PARITY_EN
    // Stored bit is the XOR of the byte, so byte plus parity holds an even count of ones.
    always_comb begin
        par_d = par_q;
        if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) par_d[wr_addr][i] = (^wr_data[8*i +: 8]) ^ wr_par_flip;
            end
        end
    end
`endif

    // Write-through mode reads the next-state array, which already holds the merged word.
    always_comb begin
        rd_word = '0;
`ifdef RAM_PARITY_EN
        rd_par  = '0;
        rd_perr = 1'b0;
`endif
        if (rd_in_range) begin
            rd_word = (COLLISION_MODE == 1) ? mem_d[rd_addr] : mem_q[rd_addr];
`ifdef RAM_PARITY_EN
            rd_par  = (COLLISION_MODE == 1) ? par_d[rd_addr] : par_q[rd_addr];
            for (int i = 0; i < NB; i++) begin
                rd_perr = rd_perr | ((^rd_word[8*i +: 8]) != rd_par[i]);
            end
`endif
        end
    end

    always_comb begin
        vld_d[0]  = rd_enb;
        data_d[0] = rd_word;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
        // Only the output stage holds its data across idle cycles.
        if (!vld_d[RD_LATENCY-1]) data_d[RD_LATENCY-1] = data_q[RD_LATENCY-1];
        addr_err_d = (wr_enb & (|wr_be) & ~wr_in_range) | (rd_enb & ~rd_in_range);
    end

`ifdef RAM_PARITY_EN
    always_comb begin
        perr_d[0] = rd_enb & rd_perr;
        for (int i = 1; i < RD_LATENCY; i++) begin
            perr_d[i] = vld_q[i-1] & perr_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q  <= '{default: '0};
            perr_q <= '{default: 1'b0};
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q[RD_LATENCY-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            vld_q      <= '{default: 1'b0};
            data_q     <= '{default: '0};
            addr_err_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_valid = vld_q[RD_LATENCY-1];
    assign rd_data  = data_q[RD_LATENCY-1];
    assign addr_err = addr_err_q;
endmodule
